// File: rtl/operand_mem_pkg.sv
// Shared constants, state encoding and helpers for the operand store.
package operand_mem_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefWords     = 128;
  localparam int unsigned DefNumSlots  = 4;
  localparam int unsigned DefOutReg    = 1;

  localparam int unsigned SLOT_R  = 0;
  localparam int unsigned SLOT_R2 = 1;
  localparam int unsigned SLOT_N  = 2;
  localparam int unsigned SLOT_E  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRead,
    StDrain
  } state_e;

  function automatic int unsigned read_latency(input int unsigned out_reg);
    return 1 + out_reg;
  endfunction

  // A single slot still needs a 1-bit select port.
  function automatic int unsigned slot_bits(input int unsigned num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/operand_mem_ram.sv
// Inferred single-port synchronous RAM with an enabled, resettable read register.
module operand_mem_ram #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 512,
  parameter int unsigned AddrW = 9
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [AddrW-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only moves on burst reads so q holds between bursts.
  always_ff @(posedge clock) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/operand_mem.sv
// Multi-slot operand store: stream loader, burst reader and output pipeline.
// Optional even-parity protection enabled by defining OPERAND_MEM_PARITY_EN.
module operand_mem
  import operand_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned WORDS      = DefWords,
  parameter int unsigned NUM_SLOTS  = DefNumSlots,
  parameter int unsigned OUT_REG    = DefOutReg
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [slot_bits(NUM_SLOTS)-1:0]    load_slot,
  input  logic [DATA_WIDTH-1:0]              load_data,
  input  logic                               load_last,
  input  logic                               rd_start,
  input  logic [slot_bits(NUM_SLOTS)-1:0]    rd_slot,
  output logic                               rd_busy,
  output logic [DATA_WIDTH-1:0]              q,
  output logic                               q_valid,
`ifdef OPERAND_MEM_PARITY_EN
  output logic                               q_last,
  output logic                               parity_err
`else
  output logic                               q_last
`endif
);

  localparam int unsigned SlotW   = slot_bits(NUM_SLOTS);
  localparam int unsigned IdxW    = $clog2(WORDS);
  localparam int unsigned AddrW   = SlotW + IdxW;
  localparam int unsigned Latency = read_latency(OUT_REG);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);
`ifdef OPERAND_MEM_PARITY_EN
  localparam int unsigned RamW = DATA_WIDTH + 1;
`else
  localparam int unsigned RamW = DATA_WIDTH;
`endif

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic [SlotW-1:0]   slot_q;
  logic               idx_last;
  logic               ram_we;
  logic               ram_re;
  logic [AddrW-1:0]   ram_addr;
  logic [RamW-1:0]    ram_wdata;
  logic [RamW-1:0]    ram_rdata;
  logic               v1_q;
  logic               last1_q;

  assign idx_last   = (idx_q == LastIdx);
  assign load_ready = resetn && (((state_q == StIdle) && !rd_start) || (state_q == StLoad));
  assign ram_we     = load_valid && load_ready;
  assign ram_re     = (state_q == StRead);
  assign rd_busy    = (state_q == StRead) || (state_q == StDrain);

  // The first beat of a load addresses word 0 of the slot presented on that beat.
  always_comb begin
    ram_addr = {slot_q, idx_q};
    if (state_q == StIdle) begin
      ram_addr = {load_slot, {IdxW{1'b0}}};
    end
  end

`ifdef OPERAND_MEM_PARITY_EN
  assign ram_wdata = {^load_data, load_data};
`else
  assign ram_wdata = load_data;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      slot_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_start) begin
            slot_q  <= rd_slot;
            idx_q   <= '0;
            state_q <= StRead;
          end else if (load_valid) begin
            slot_q <= load_slot;
            if (load_last) begin
              idx_q <= '0;
            end else begin
              idx_q   <= IdxW'(1);
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (load_valid) begin
            if (load_last || idx_last) begin
              idx_q   <= '0;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StRead: begin
          if (idx_last) begin
            idx_q   <= '0;
            state_q <= StDrain;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDrain: begin
          if (q_last) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  operand_mem_ram #(
    .Width (RamW),
    .Depth (NUM_SLOTS * WORDS),
    .AddrW (AddrW)
  ) u_ram (
    .clock (clock),
    .rst   (!resetn),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Flags travelling alongside the RAM read register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      v1_q    <= ram_re;
      last1_q <= ram_re && idx_last;
    end
  end

  if (Latency == 2) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_q;
    logic                  q_valid_q;
    logic                  q_last_q;
`ifdef OPERAND_MEM_PARITY_EN
    logic                  perr_q;
`endif

    always_ff @(posedge clock) begin
      if (!resetn) begin
        q_q       <= '0;
        q_valid_q <= 1'b0;
        q_last_q  <= 1'b0;
`ifdef OPERAND_MEM_PARITY_EN
        perr_q    <= 1'b0;
`endif
      end else begin
        q_valid_q <= v1_q;
        q_last_q  <= last1_q;
        if (v1_q) begin
          q_q <= ram_rdata[DATA_WIDTH-1:0];
        end
`ifdef OPERAND_MEM_PARITY_EN
        perr_q <= v1_q && (^ram_rdata);
`endif
      end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_last  = q_last_q;
`ifdef OPERAND_MEM_PARITY_EN
    assign parity_err = perr_q;
`endif
  end else begin : g_no_out_reg
    assign q       = ram_rdata[DATA_WIDTH-1:0];
    assign q_valid = v1_q;
    assign q_last  = last1_q;
`ifdef OPERAND_MEM_PARITY_EN
    assign parity_err = v1_q && (^ram_rdata);
`endif
  end

endmodule

// File: tb/tb_operand_mem.sv
// Scoreboard bench for operand_mem: directed loads, bursts, collisions and reset abort.
module tb_operand_mem;
  import operand_mem_pkg::*;

  localparam int unsigned DW      = 32;
  localparam int unsigned WORDS   = 128;
  localparam int unsigned NS      = 4;
  localparam int unsigned OUT_REG = 1;
  // Cycles from the rd_start cycle to the first q_valid.
  localparam int Lat = 2 + int'(OUT_REG);

  logic          clock = 1'b0;
  logic          resetn;
  logic          load_valid;
  logic          load_ready;
  logic [1:0]    load_slot;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          rd_start;
  logic [1:0]    rd_slot;
  logic          rd_busy;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          q_last;
`ifdef OPERAND_MEM_PARITY_EN
  logic          parity_err;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          perr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   nvalid = 0;

  always #5 clock = ~clock;

  operand_mem #(
    .DATA_WIDTH (DW),
    .WORDS      (WORDS),
    .NUM_SLOTS  (NS),
    .OUT_REG    (OUT_REG)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_slot  (load_slot),
    .load_data  (load_data),
    .load_last  (load_last),
    .rd_start   (rd_start),
    .rd_slot    (rd_slot),
    .rd_busy    (rd_busy),
    .q          (q),
    .q_valid    (q_valid),
`ifdef OPERAND_MEM_PARITY_EN
    .q_last     (q_last),
    .parity_err (parity_err)
`else
    .q_last     (q_last)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every presented word is matched against the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (q_valid === 1'b1) begin
      nvalid++;
      if (exp_q.size() == 0) begin
        check("unexpected_q_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("q_data", q, e.data);
        check("q_last", {31'd0, q_last}, {31'd0, e.last});
`ifdef OPERAND_MEM_PARITY_EN
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] d, input logic last, input logic perr);
    exp_t e;
    e.data = d;
    e.last = last;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  task automatic push_range(input logic [DW-1:0] base, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      push_word(base + DW'(i), (i == int'(WORDS) - 1), 1'b0);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic load_beat(input logic [1:0] slot, input logic [DW-1:0] d, input logic last);
    int n;
    load_valid = 1'b1;
    load_slot  = slot;
    load_data  = d;
    load_last  = last;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!load_ready && n < 20);
    if (!load_ready) check("load_ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic load_range(input logic [1:0] slot, input logic [DW-1:0] base,
                            input logic [DW-1:0] step, input int n);
    for (int i = 0; i < n; i++) begin
      load_beat(slot, base + DW'(i) * step, (i == n - 1));
    end
  endtask

  task automatic run_burst(input logic [1:0] slot, input bit collide, input bit mid,
                           input int exp_words);
    int first;
    int bad;
    bit seen_last;
    nvalid    = 0;
    first     = 0;
    bad       = 0;
    seen_last = 1'b0;
    rd_start  = 1'b1;
    rd_slot   = slot;
    if (collide) begin
      load_valid = 1'b1;
      load_slot  = 2'(SLOT_R);
      load_data  = 32'hDEAD_BEEF;
      load_last  = 1'b1;
    end
    @(negedge clock);
    check("ready_low_with_rd_start", {31'd0, load_ready}, 32'd0);
    @(posedge clock);
    #1;
    rd_start = 1'b0;
    for (int c = 1; c < 400; c++) begin
      @(negedge clock);
      if (q_valid && first == 0) first = c;
      if (rd_busy && load_ready) bad++;
      if (mid) begin
        rd_start = (c == 50);
        rd_slot  = 2'(SLOT_R);
      end
      if (q_last) begin
        seen_last  = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        rd_start   = 1'b0;
      end else if (seen_last) begin
        break;
      end
    end
    check("first_q_valid_latency", first, Lat);
    check("ready_low_while_busy", bad, 0);
    check("burst_completed", {31'd0, seen_last}, 32'd1);
    check("busy_cleared", {31'd0, rd_busy}, 32'd0);
    check("q_valid_count", nvalid, exp_words);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int act;
    resetn     = 1'b0;
    load_valid = 1'b0;
    load_slot  = '0;
    load_data  = '0;
    load_last  = 1'b0;
    rd_start   = 1'b0;
    rd_slot    = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_load_ready", {31'd0, load_ready}, 32'd0);
    check("reset_rd_busy", {31'd0, rd_busy}, 32'd0);
    check("reset_q_valid", {31'd0, q_valid}, 32'd0);
    check("reset_q_last", {31'd0, q_last}, 32'd0);
    check("reset_q", q, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    check("idle_load_ready", {31'd0, load_ready}, 32'd1);
    @(posedge clock);
    #1;

    // Load then read slot N.
    load_range(2'(SLOT_N), 32'h1000_0000, 32'd1, WORDS);
    push_range(32'h1000_0000, 0, WORDS);
    run_burst(2'(SLOT_N), 1'b0, 1'b0, WORDS);

    // Early last leaves the upper words untouched.
    load_range(2'(SLOT_R2), 32'hAAAA_AAAA, 32'd0, WORDS);
    load_beat(2'(SLOT_R2), 32'd1, 1'b0);
    load_beat(2'(SLOT_R2), 32'd2, 1'b0);
    load_beat(2'(SLOT_R2), 32'd3, 1'b1);
    push_word(32'd1, 1'b0, 1'b0);
    push_word(32'd2, 1'b0, 1'b0);
    push_word(32'd3, 1'b0, 1'b0);
    for (int i = 3; i < int'(WORDS); i++) push_word(32'hAAAA_AAAA, (i == int'(WORDS) - 1), 1'b0);
    @(posedge clock);
    #1;
    run_burst(2'(SLOT_R2), 1'b0, 1'b0, WORDS);

    // Collision with a load beat plus a stray mid-burst rd_start.
    push_range(32'h1000_0000, 0, WORDS);
    @(posedge clock);
    #1;
    run_burst(2'(SLOT_N), 1'b1, 1'b1, WORDS);

    // Reset while word 39 is on q.
    @(posedge clock);
    #1;
    push_range(32'h1000_0000, 0, 40);
    rd_start = 1'b1;
    rd_slot  = 2'(SLOT_N);
    @(posedge clock);
    #1;
    rd_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (q_valid && q == 32'h1000_0027) begin
        resetn = 1'b0;
        found  = 1'b1;
        break;
      end
    end
    check("reset_point_reached", {31'd0, found}, 32'd1);
    @(negedge clock);
    check("abort_q_valid", {31'd0, q_valid}, 32'd0);
    check("abort_rd_busy", {31'd0, rd_busy}, 32'd0);
    check("abort_q", q, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    act = 0;
    repeat (10) begin
      @(negedge clock);
      if (q_valid || rd_busy) act++;
    end
    check("no_activity_after_abort", act, 0);
    check("abort_scoreboard_drained", exp_q.size(), 0);
    push_range(32'h1000_0000, 0, WORDS);
    @(posedge clock);
    #1;
    run_burst(2'(SLOT_N), 1'b0, 1'b0, WORDS);

    // Implicit end at WORDS beats; slot is sampled only on first beats.
    @(posedge clock);
    #1;
    load_range(2'(SLOT_E), 32'h3300_0000, 32'd1, WORDS);
    load_beat(2'(SLOT_R), 32'h5000_0000, 1'b0);
    for (int i = 1; i < int'(WORDS); i++) load_beat(2'(SLOT_R2), 32'h5000_0000 + DW'(i), 1'b0);
    load_beat(2'(SLOT_E), 32'h3000_0000, 1'b0);
    load_beat(2'(SLOT_R), 32'h3000_0001, 1'b1);
    push_range(32'h5000_0000, 0, WORDS);
    run_burst(2'(SLOT_R), 1'b0, 1'b0, WORDS);
    push_word(32'h3000_0000, 1'b0, 1'b0);
    push_word(32'h3000_0001, 1'b0, 1'b0);
    push_range(32'h3300_0000, 2, WORDS - 2);
    @(posedge clock);
    #1;
    run_burst(2'(SLOT_E), 1'b0, 1'b0, WORDS);
    push_word(32'd1, 1'b0, 1'b0);
    push_word(32'd2, 1'b0, 1'b0);
    push_word(32'd3, 1'b0, 1'b0);
    for (int i = 3; i < int'(WORDS); i++) push_word(32'hAAAA_AAAA, (i == int'(WORDS) - 1), 1'b0);
    @(posedge clock);
    #1;
    run_burst(2'(SLOT_R2), 1'b0, 1'b0, WORDS);

`ifdef OPERAND_MEM_PARITY_EN
    // Corrupt one stored bit of word 5 in slot E; only that word flags.
    dut.u_ram.mem[SLOT_E * WORDS + 5] = dut.u_ram.mem[SLOT_E * WORDS + 5] ^ 33'h1;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (i == 0) push_word(32'h3000_0000, 1'b0, 1'b0);
      else if (i == 1) push_word(32'h3000_0001, 1'b0, 1'b0);
      else if (i == 5) push_word(32'h3300_0004, 1'b0, 1'b1);
      else push_word(32'h3300_0000 + DW'(i), (i == int'(WORDS) - 1), 1'b0);
    end
    @(posedge clock);
    #1;
    run_burst(2'(SLOT_E), 1'b0, 1'b0, WORDS);
`endif

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
